// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller.
// Accepts Rs 5/10/20 coins up to MAX_CREDIT, vends one of N_ITEMS products
// against per-item price and stock, and returns leftover credit as a train of
// Rs 5 change pulses.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   coin_5/coin_10/coin_20      one-cycle coin strobes
//   sel[N_ITEMS]                one-hot product select strobe
//   cancel, restock             refund request, stock refill (IDLE only)
//   dispense, dispense_id       one-cycle vend pulse and item index
//   change_5                    one pulse per Rs 5 returned
//   coin_reject, sel_err        one-cycle error pulses
//   credit, sold_out, busy      status: credit, per-item empty flags, VEND/CHANGE
module vend_ctrl_multi #(
  parameter int unsigned N_ITEMS = 4,
  parameter int unsigned CREDIT_W = 8,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {4{8'd15}},
  parameter int unsigned MAX_CREDIT = 50,
  parameter int unsigned STOCK_W = 4,
  parameter int unsigned STOCK_INIT = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         coin_5,
  input  logic                         coin_10,
  input  logic                         coin_20,
  input  logic [N_ITEMS-1:0]           sel,
  input  logic                         cancel,
  input  logic                         restock,
  output logic                         dispense,
  output logic [$clog2(N_ITEMS)-1:0]   dispense_id,
  output logic                         change_5,
  output logic                         coin_reject,
  output logic                         sel_err,
  output logic [CREDIT_W-1:0]          credit,
  output logic [N_ITEMS-1:0]           sold_out,
  output logic                         busy
);

  localparam int unsigned ID_W  = $clog2(N_ITEMS);
  localparam int unsigned SUM_W = CREDIT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [STOCK_W-1:0]  r_stock [N_ITEMS];
  logic                r_dispense;
  logic [ID_W-1:0]     r_dispense_id;
  logic                r_change_5;
  logic                r_coin_reject;
  logic                r_sel_err;

  logic [1:0]          w_ncoins;
  logic                w_coin_any;
  logic [SUM_W-1:0]    w_coin_val;
  logic [SUM_W-1:0]    w_sum;
  logic                w_coin_ok;
  logic                w_sel_req;
  logic                w_sel_onehot;
  logic [ID_W-1:0]     w_idx;
  logic [CREDIT_W-1:0] w_price;
  logic [STOCK_W-1:0]  w_stock_sel;
  logic                w_sel_ok;

  // Coin decode: exactly one strobe that keeps credit within the limit is accepted
  assign w_ncoins   = 2'(coin_5) + 2'(coin_10) + 2'(coin_20);
  assign w_coin_any = coin_5 | coin_10 | coin_20;
  assign w_coin_val = coin_20 ? SUM_W'(20) : (coin_10 ? SUM_W'(10) : (coin_5 ? SUM_W'(5) : '0));
  assign w_sum      = {1'b0, r_credit} + w_coin_val;
  assign w_coin_ok  = w_coin_any && (w_ncoins == 2'd1) && (w_sum <= SUM_W'(MAX_CREDIT));

  // Selection decode: index of the set bit, its price and remaining stock
  assign w_sel_req    = |sel;
  assign w_sel_onehot = w_sel_req && ((sel & (sel - N_ITEMS'(1))) == '0);

  always_comb begin
    w_idx = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (sel[i]) w_idx = ID_W'(i);
    end
  end

  assign w_price     = PRICES[w_idx*CREDIT_W +: CREDIT_W];
  assign w_stock_sel = r_stock[w_idx];
  assign w_sel_ok    = w_sel_onehot && (w_stock_sel != '0) && (r_credit >= w_price);

  // Controller state, credit, stock and registered pulse outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_credit      <= '0;
      for (int unsigned i = 0; i < N_ITEMS; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
      r_dispense    <= 1'b0;
      r_dispense_id <= '0;
      r_change_5    <= 1'b0;
      r_coin_reject <= 1'b0;
      r_sel_err     <= 1'b0;
    end else begin
      r_dispense    <= 1'b0;
      r_change_5    <= 1'b0;
      r_coin_reject <= 1'b0;
      r_sel_err     <= 1'b0;
      case (r_state)
        S_IDLE, S_CREDIT: begin
          if ((r_state == S_CREDIT) && cancel) begin
            // Refund wins over sel; any coin in the same cycle is bounced
            r_coin_reject <= w_coin_any;
            r_state       <= S_CHANGE;
          end else begin
            if (w_coin_ok) begin
              r_credit <= w_sum[CREDIT_W-1:0];
              r_state  <= S_CREDIT;
            end else if (w_coin_any) begin
              r_coin_reject <= 1'b1;
            end
            // Vend only on a clean select cycle; any coin strobe voids the sel
            if (w_sel_req) begin
              if ((r_state == S_CREDIT) && !w_coin_any && w_sel_ok) begin
                r_state          <= S_VEND;
                r_credit         <= r_credit - w_price;
                r_stock[w_idx]   <= w_stock_sel - STOCK_W'(1);
                r_dispense       <= 1'b1;
                r_dispense_id    <= w_idx;
              end else begin
                r_sel_err <= 1'b1;
              end
            end
            if ((r_state == S_IDLE) && restock) begin
              for (int unsigned i = 0; i < N_ITEMS; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
            end
          end
        end
        S_VEND: begin
          r_coin_reject <= w_coin_any;
          r_state       <= (r_credit != '0) ? S_CHANGE : S_IDLE;
        end
        S_CHANGE: begin
          r_coin_reject <= w_coin_any;
          if (r_credit != '0) begin
            r_credit   <= r_credit - CREDIT_W'(5);
            r_change_5 <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Status decoded from registered state only
  always_comb begin
    sold_out = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) sold_out[i] = (r_stock[i] == '0);
  end

  assign busy        = (r_state == S_VEND) || (r_state == S_CHANGE);
  assign credit      = r_credit;
  assign dispense    = r_dispense;
  assign dispense_id = r_dispense_id;
  assign change_5    = r_change_5;
  assign coin_reject = r_coin_reject;
  assign sel_err     = r_sel_err;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Scoreboard bench for vend_ctrl_multi: a transaction-level model predicts
// pulses into queues, a negedge monitor pops and compares them.
module tb_vend_ctrl_multi;

  localparam int MAXC = 50;
  localparam int INIT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_5 = 1'b0, coin_10 = 1'b0, coin_20 = 1'b0;
  logic [3:0] sel = 4'b0;
  logic       cancel = 1'b0, restock = 1'b0;
  logic       dispense;
  logic [1:0] dispense_id;
  logic       change_5, coin_reject, sel_err;
  logic [7:0] credit;
  logic [3:0] sold_out;
  logic       busy;

  vend_ctrl_multi #(
    .N_ITEMS(4), .CREDIT_W(8), .PRICES({8'd15, 8'd25, 8'd15, 8'd15}),
    .MAX_CREDIT(50), .STOCK_W(4), .STOCK_INIT(8)
  ) dut (
    .clk(clk), .reset(reset), .coin_5(coin_5), .coin_10(coin_10), .coin_20(coin_20),
    .sel(sel), .cancel(cancel), .restock(restock), .dispense(dispense),
    .dispense_id(dispense_id), .change_5(change_5), .coin_reject(coin_reject),
    .sel_err(sel_err), .credit(credit), .sold_out(sold_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_credit = 0;
  int m_stock[4] = '{INIT, INIT, INIT, INIT};
  int m_price[4] = '{15, 15, 25, 15};

  // Expected pulse queues
  int q_disp[$];
  int q_chg[$];
  bit q_rej[$];
  bit q_serr[$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  // Transaction-level rules: what one stimulus cycle does from a non-busy state
  task automatic model_apply(input bit c5, input bit c10, input bit c20,
                             input logic [3:0] s, input bit cn, input bit rs,
                             output bit busy_after);
    int n, val, old, idx;
    bit ok;
    busy_after = 1'b0;
    n   = int'(c5) + int'(c10) + int'(c20);
    val = c20 ? 20 : (c10 ? 10 : (c5 ? 5 : 0));
    old = m_credit;
    if (old > 0 && cn) begin
      if (n > 0) q_rej.push_back(1'b1);
      q_chg.push_back(old / 5);
      m_credit = 0;
      busy_after = 1'b1;
      return;
    end
    ok = (n == 1) && (old + val <= MAXC);
    if (n > 0 && !ok) q_rej.push_back(1'b1);
    if (ok) m_credit = old + val;
    if (s != 4'b0) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (s[i]) idx = i;
      if (old > 0 && n == 0 && $countones(s) == 1 && m_stock[idx] > 0 && old >= m_price[idx]) begin
        q_disp.push_back(idx);
        m_stock[idx] = m_stock[idx] - 1;
        m_credit = old - m_price[idx];
        if (m_credit > 0) q_chg.push_back(m_credit / 5);
        m_credit = 0;
        busy_after = 1'b1;
      end else begin
        q_serr.push_back(1'b1);
      end
    end
    if (old == 0 && rs) for (int i = 0; i < 4; i++) m_stock[i] = INIT;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    chk("busy_timeout", int'(busy), 0);
  endtask

  task automatic drive(input bit c5, input bit c10, input bit c20,
                       input logic [3:0] s, input bit cn, input bit rs);
    bit busy_after;
    model_apply(c5, c10, c20, s, cn, rs, busy_after);
    coin_5 = c5; coin_10 = c10; coin_20 = c20; sel = s; cancel = cn; restock = rs;
    @(posedge clk); #1;
    coin_5 = 0; coin_10 = 0; coin_20 = 0; sel = 4'b0; cancel = 0; restock = 0;
    if (busy_after) begin
      // A coin offered while the machine is busy must bounce
      if ($urandom_range(0, 1) == 1) begin
        coin_10 = 1'b1;
        q_rej.push_back(1'b1);
        @(posedge clk); #1;
        coin_10 = 1'b0;
      end
      wait_idle();
    end
  endtask

  task automatic check_state(input string tag);
    logic [3:0] exp_so;
    for (int i = 0; i < 4; i++) exp_so[i] = (m_stock[i] == 0);
    chk({tag, "_credit"}, int'(credit), m_credit);
    chk({tag, "_sold_out"}, int'(sold_out), int'(exp_so));
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse
  int run = 0;
  always @(negedge clk) begin
    int e;
    if (reset) begin
      run = 0;
    end else begin
      if (dispense) begin
        checks++;
        if (q_disp.size() == 0) begin
          errors++;
          $display("FAIL dispense_unexpected got id %0d exp none", dispense_id);
        end else begin
          e = q_disp.pop_front();
          if (int'(dispense_id) != e) begin
            errors++;
            $display("FAIL dispense_id got %0d exp %0d", dispense_id, e);
          end
        end
      end
      if (change_5) begin
        run++;
      end else if (run > 0) begin
        checks++;
        if (q_chg.size() == 0) begin
          errors++;
          $display("FAIL change_unexpected got run %0d exp none", run);
        end else begin
          e = q_chg.pop_front();
          if (run != e) begin
            errors++;
            $display("FAIL change_run got %0d exp %0d", run, e);
          end
        end
        run = 0;
      end
      if (coin_reject) begin
        checks++;
        if (q_rej.size() == 0) begin
          errors++;
          $display("FAIL coin_reject_unexpected got 1 exp 0");
        end else void'(q_rej.pop_front());
      end
      if (sel_err) begin
        checks++;
        if (q_serr.size() == 0) begin
          errors++;
          $display("FAIL sel_err_unexpected got 1 exp 0");
        end else void'(q_serr.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] s;
    logic [2:0] v;
    int r;
    bit c5, c10, c20;

    // Reset values while reset is held
    #12;
    chk("rst_credit", int'(credit), 0);
    chk("rst_dispense", int'(dispense), 0);
    chk("rst_dispense_id", int'(dispense_id), 0);
    chk("rst_change_5", int'(change_5), 0);
    chk("rst_coin_reject", int'(coin_reject), 0);
    chk("rst_sel_err", int'(sel_err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sold_out", int'(sold_out), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_state("post_reset");

    // Basic vend with exact credit
    drive(0, 1, 0, 4'b0000, 0, 0); chk("t29_credit10", int'(credit), 10);
    drive(1, 0, 0, 4'b0000, 0, 0); chk("t29_credit15", int'(credit), 15);
    drive(0, 0, 0, 4'b0001, 0, 0); chk("t29_credit0", int'(credit), 0);
    check_state("t29");

    // Vend with one Rs 5 of change
    drive(0, 0, 1, 4'b0000, 0, 0);
    drive(0, 0, 0, 4'b0010, 0, 0);
    check_state("t30");

    // Credit ceiling then full refund
    drive(0, 0, 1, 4'b0000, 0, 0);
    drive(0, 0, 1, 4'b0000, 0, 0);
    drive(0, 0, 1, 4'b0000, 0, 0); chk("t31_credit40", int'(credit), 40);
    drive(0, 0, 0, 4'b0000, 1, 0);
    check_state("t31");

    // Double coin rejected, insufficient credit select
    drive(1, 1, 0, 4'b0000, 0, 0); chk("t32_credit0", int'(credit), 0);
    drive(1, 0, 0, 4'b0000, 0, 0);
    drive(0, 0, 0, 4'b0100, 0, 0); chk("t32_credit5", int'(credit), 5);
    drive(0, 0, 0, 4'b0000, 1, 0);
    check_state("t32");

    // Sell out item 3, then restock
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 4'b0000, 0, 0);
      drive(1, 0, 0, 4'b0000, 0, 0);
      drive(0, 0, 0, 4'b1000, 0, 0);
    end
    chk("t33_sold_out", int'(sold_out), 8);
    drive(0, 1, 0, 4'b0000, 0, 0);
    drive(1, 0, 0, 4'b0000, 0, 0);
    drive(0, 0, 0, 4'b1000, 0, 0); chk("t33_credit15", int'(credit), 15);
    drive(0, 0, 0, 4'b0000, 1, 0);
    drive(0, 0, 0, 4'b0000, 0, 1); chk("t33_restock", int'(sold_out), 0);
    check_state("t33");

    // Randomized traffic
    for (int op = 0; op < 300; op++) begin
      c5 = 0; c10 = 0; c20 = 0;
      r = $urandom_range(0, 9);
      if (r < 4) begin
        r = $urandom_range(0, 2);
        c5 = (r == 0); c10 = (r == 1); c20 = (r == 2);
      end else if (r == 4) begin
        v = 3'($urandom_range(0, 7));
        c5 = v[0]; c10 = v[1]; c20 = v[2];
      end
      r = $urandom_range(0, 9);
      if (r < 4) s = 4'(1 << $urandom_range(0, 3));
      else if (r == 4) s = 4'($urandom_range(0, 15));
      else s = 4'b0;
      drive(c5, c10, c20, s, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
      check_state("rand");
    end

    // Reset in the middle of a refund discards the credit
    drive(0, 0, 1, 4'b0000, 0, 0);
    drive(1, 0, 0, 4'b0000, 0, 0); chk("t34_credit25", int'(credit), 25);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("t34_busy_change", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("t34_credit", int'(credit), 0);
    chk("t34_change_5", int'(change_5), 0);
    chk("t34_busy", int'(busy), 0);
    m_credit = 0;
    for (int i = 0; i < 4; i++) m_stock[i] = INIT;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_state("t34_after");

    // Every predicted pulse must have been seen
    repeat (4) @(posedge clk);
    #1;
    chk("left_dispense", q_disp.size(), 0);
    chk("left_change", q_chg.size(), 0);
    chk("left_reject", q_rej.size(), 0);
    chk("left_sel_err", q_serr.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
